// File: rtl/wb_fuzz_target.sv
// Wishbone classic target: byte-maskable register file, programmable ack latency,
// err on illegal addresses, sticky error interrupt and saturating counters.
// Optional hang injection is built when WB_TARGET_HANG_INJECT_EN is defined.
module wb_fuzz_target #(
  parameter int NUM_REGS    = 16,
  parameter int ACK_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  input  logic [3:0]  wb_sel,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic        wb_we,
  output logic [31:0] wb_data_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        int_,
  output logic [15:0] access_count,
  output logic [7:0]  err_count
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [7:0]       lat_cnt;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [3:0]       sel_q;
  logic             we_q;
  logic [31:0]      regs [NUM_REGS];

  logic             accept;
  logic             do_resp;
  logic             hang_armed;
  logic             hang_active;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_data;
  logic [3:0]       cur_sel;
  logic             cur_we;
  logic             cur_legal;
  logic [IDX_W-1:0] cur_idx;

  assign accept = (state == S_IDLE) && wb_cyc && wb_stb;

  // With zero latency the response is produced on the sampling edge itself,
  // so the transaction fields come straight from the bus while in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    do_resp  = 1'b0;
    cur_addr = addr_q;
    cur_data = data_q;
    cur_sel  = sel_q;
    cur_we   = we_q;
    if (state == S_IDLE) begin
      cur_addr = wb_addr;
      cur_data = wb_data;
      cur_sel  = wb_sel;
      cur_we   = wb_we;
      do_resp  = accept && (ACK_LATENCY == 0) && !hang_armed;
    end else if (state == S_WAIT) begin
      do_resp  = wb_cyc && (lat_cnt <= 8'd1) && !hang_active;
    end
  end

  assign cur_idx   = cur_addr[2 +: IDX_W];
  assign cur_legal = (cur_addr[1:0] == 2'b00) && ((cur_addr >> (IDX_W + 2)) == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          addr_q  <= wb_addr;
          data_q  <= wb_data;
          sel_q   <= wb_sel;
          we_q    <= wb_we;
          lat_cnt <= 8'(ACK_LATENCY);
          state   <= do_resp ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (!wb_cyc)             state   <= S_IDLE;
          else if (do_resp)        state   <= S_RESP;
          else if (lat_cnt != '0)  lat_cnt <= lat_cnt - 8'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response pulse, register commit, read data, interrupt and counters all
  // move together on the edge that raises wb_ack or wb_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is reset explicitly because software relies on
      // reading zeros after reset; this keeps it in flops rather than RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb_data_o    <= '0;
      wb_ack       <= 1'b0;
      wb_err       <= 1'b0;
      int_         <= 1'b0;
      access_count <= '0;
      err_count    <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (do_resp) begin
        if (cur_legal) begin
          wb_ack <= 1'b1;
          if (access_count != 16'hFFFF) access_count <= access_count + 16'd1;
          if (cur_we) begin
            for (int b = 0; b < 4; b++)
              if (cur_sel[b]) regs[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
            if (cur_idx == IDX_W'(NUM_REGS - 1) && cur_sel[0] && cur_data[0])
              int_ <= 1'b0;
          end else begin
            wb_data_o <= regs[cur_idx];
          end
        end else begin
          wb_err    <= 1'b1;
          wb_data_o <= '0;
          int_      <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

`ifdef WB_TARGET_HANG_INJECT_EN
  // Arming takes effect after the arming write completes; the next accepted
  // transaction then parks in WAIT until cyc drops or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_armed  <= 1'b0;
      hang_active <= 1'b0;
    end else if (state == S_WAIT && !wb_cyc) begin
      hang_armed  <= 1'b0;
      hang_active <= 1'b0;
    end else begin
      if (accept) hang_active <= hang_armed;
      if (do_resp && cur_legal && cur_we && cur_sel == 4'hF &&
          cur_data == 32'hDEAD_BEEF && cur_idx == IDX_W'(NUM_REGS - 2))
        hang_armed <= 1'b1;
    end
  end
`else
  assign hang_armed  = 1'b0;
  assign hang_active = 1'b0;
`endif

endmodule
